bcd_converter: RTL and testbench

//  Sequential binary-to-BCD converter (iterative shift-add-3 / double-dabble) for the reaction-time result.

---
 rtl/bcd_converter.sv | 124 ++++++++++++
 tb/tb_bcd_converter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// Purpose : iterative binary-to-BCD converter (shift-add-3), saturating to all nines on overflow.
// Latency : done seen BIN_W+1 edges after the accepting edge, counting that edge (14 by default).
//           Back-to-back starts give one result every BIN_W+1 clocks.
// Backpressure: start is ignored while busy; it is accepted in IDLE or in the DONE cycle.
// Ports:
//   clk       system clock, rising edge
//   ck_rst    asynchronous active-high reset
//   start     conversion request, sampled while busy=0
//   bin_in    unsigned binary input, sampled on the accepting edge only
//   busy      high while shifting
//   done      one-cycle pulse, bcd_out/overflow valid and freshly updated
//   bcd_out   packed BCD result, [3:0]=ones; holds last result
//   overflow  last input exceeded 10^DIGITS-1; holds with bcd_out
module bcd_converter #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  ck_rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_display();
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < DIGITS; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0]      MAX_VAL  = max_display();
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shifted;

  // Add-3 on every BCD nibble that is 5 or more; the value is at most 9 before
  // the add, so the 4-bit result never carries into the next nibble.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    sr_shifted = {sr_adj[SR_W-2:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sr_d       = {{BCD_W{1'b0}}, bin_in};
          cnt_d      = '0;
          ovf_pend_d = (64'(bin_in) > MAX_VAL);
          state_d    = SHIFT;
        end else begin
          state_d    = IDLE;
        end
      end
      SHIFT: begin
        sr_d  = sr_shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          // Result is registered on the final shift edge so that it is already
          // on bcd_out during the done cycle.
          bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : sr_shifted[SR_W-1 -: BCD_W];
          ovf_d   = ovf_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_converter.sv
module tb_bcd_converter;

  logic        clk = 1'b0;
  logic        ck_rst = 1'b0;
  logic        start = 1'b0;
  logic [12:0] bin_in = '0;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;

  logic        start14 = 1'b0;
  logic [13:0] bin14 = '0;
  logic        busy14, done14, overflow14;
  logic [15:0] bcd14;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bcd_converter #(.BIN_W(13), .DIGITS(4)) dut (
    .clk(clk), .ck_rst(ck_rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  bcd_converter #(.BIN_W(14), .DIGITS(4)) dut14 (
    .clk(clk), .ck_rst(ck_rst), .start(start14), .bin_in(bin14),
    .busy(busy14), .done(done14), .bcd_out(bcd14), .overflow(overflow14)
  );

  // Pulse start for one edge from idle, then wait (bounded) for done.
  // lat counts edges from the accepting edge up to and including the edge that raised done.
  task automatic run_conv(input logic [12:0] v, output int lat, output int busy_n,
                          output logic [15:0] r, output logic o);
    start = 1'b1; bin_in = v;
    @(negedge clk);
    start = 1'b0; bin_in = ~v;
    lat = 1; busy_n = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    r = bcd_out; o = overflow;
  endtask

  task automatic run_conv14(input logic [13:0] v, output int lat,
                            output logic [15:0] r, output logic o);
    start14 = 1'b1; bin14 = v;
    @(negedge clk);
    start14 = 1'b0; bin14 = ~v;
    lat = 1;
    while (done14 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = bcd14; o = overflow14;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ck_rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, overflow, bcd_out} !== 19'd0) $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b bcd=%h, want all 0", busy, done, overflow, bcd_out);
    else pass_cnt++;
    total_cnt++;
    if ({busy14, done14, overflow14, bcd14} !== 19'd0) $display("FAIL reset_outputs14: got busy=%b done=%b ovf=%b bcd=%h, want all 0", busy14, done14, overflow14, bcd14);
    else pass_cnt++;
    @(negedge clk);
    ck_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat, bn; logic [15:0] r; logic o;
    run_conv(13'd0, lat, bn, r, o);
    total_cnt++;
    if (lat !== 14) $display("FAIL zero_latency: got %0d, want 14", lat); else pass_cnt++;
    total_cnt++;
    if ({o, r} !== 17'h0_0000) $display("FAIL zero_result: got ovf=%b bcd=%h, want 0/0000", o, r); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bn; logic [15:0] r; logic o;
    run_conv(13'd1234, lat, bn, r, o);
    total_cnt++;
    if (bn !== 13) $display("FAIL busy_cycles_1234: got %0d, want 13", bn); else pass_cnt++;
    total_cnt++;
    if (lat !== 14) $display("FAIL latency_1234: got %0d, want 14", lat); else pass_cnt++;
    total_cnt++;
    if (r !== 16'h1234 || o !== 1'b0) $display("FAIL result_1234: got %h ovf=%b, want 1234 ovf=0", r, o); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_in_done: got %b, want 0", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 16'h1234) $display("FAIL done_pulse_hold: got done=%b busy=%b bcd=%h, want 0 0 1234", done, busy, bcd_out); else pass_cnt++;
    run_conv(13'd8191, lat, bn, r, o);
    total_cnt++;
    if (r !== 16'h8191 || o !== 1'b0) $display("FAIL result_8191: got %h ovf=%b, want 8191 ovf=0", r, o); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dcnt; logic [15:0] r;
    dcnt = 0; r = '0;
    start = 1'b1; bin_in = 13'd999;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (i >= 2 && i <= 8) begin start = 1'b1; bin_in = 13'd42; end
      else begin start = 1'b0; bin_in = 13'd42; end
      if (done === 1'b1) begin dcnt++; r = bcd_out; end
      @(negedge clk);
    end
    start = 1'b0;
    total_cnt++;
    if (dcnt !== 1) $display("FAIL ignore_done_count: got %0d, want 1", dcnt); else pass_cnt++;
    total_cnt++;
    if (r !== 16'h0999) $display("FAIL ignore_result: got %h, want 0999", r); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || bcd_out !== 16'h0999) $display("FAIL ignore_idle: got busy=%b bcd=%h, want 0 0999", busy, bcd_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, bcnt;
    start = 1'b1; bin_in = 13'd500;
    @(negedge clk);
    bin_in = 13'd501;
    n = 1;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total_cnt++;
    if (n !== 14 || bcd_out !== 16'h0500) $display("FAIL b2b_first: got lat=%0d bcd=%h, want 14 0500", n, bcd_out); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_busy_done1: got %b, want 0", busy); else pass_cnt++;
    n = 0; bcnt = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
      if (busy === 1'b1) bcnt++;
    end
    start = 1'b0;
    total_cnt++;
    if (n !== 14 || bcnt !== 13) $display("FAIL b2b_period: got period=%0d busy=%0d, want 14 13", n, bcnt); else pass_cnt++;
    total_cnt++;
    if (bcd_out !== 16'h0501 || busy !== 1'b0) $display("FAIL b2b_second: got bcd=%h busy=%b, want 0501 0", bcd_out, busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_stop: got busy=%b done=%b, want 0 0", busy, done); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bn; logic [15:0] r; logic o;
    run_conv(13'd77, lat, bn, r, o);
    total_cnt++;
    if (r !== 16'h0077) $display("FAIL result_77: got %h, want 0077", r); else pass_cnt++;
    @(negedge clk);
    start = 1'b1; bin_in = 13'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || bcd_out !== 16'h0077) $display("FAIL stable_while_busy: got busy=%b bcd=%h, want 1 0077", busy, bcd_out); else pass_cnt++;
    ck_rst = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000 || overflow !== 1'b0) $display("FAIL mid_reset: got busy=%b done=%b bcd=%h ovf=%b, want 0 0 0000 0", busy, done, bcd_out, overflow); else pass_cnt++;
    @(negedge clk);
    ck_rst = 1'b0;
    @(negedge clk);
    run_conv(13'd9, lat, bn, r, o);
    total_cnt++;
    if (r !== 16'h0009 || lat !== 14) $display("FAIL after_reset_9: got %h lat=%0d, want 0009 14", r, lat); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] r; logic o;
    run_conv14(14'd10000, lat, r, o);
    total_cnt++;
    if (r !== 16'h9999 || o !== 1'b1) $display("FAIL ovf_10000: got %h ovf=%b, want 9999 ovf=1", r, o); else pass_cnt++;
    total_cnt++;
    if (lat !== 15) $display("FAIL ovf_latency14: got %0d, want 15", lat); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (overflow14 !== 1'b1 || bcd14 !== 16'h9999) $display("FAIL ovf_hold: got %h ovf=%b, want 9999 ovf=1", bcd14, overflow14); else pass_cnt++;
    run_conv14(14'd9999, lat, r, o);
    total_cnt++;
    if (r !== 16'h9999 || o !== 1'b0) $display("FAIL no_ovf_9999: got %h ovf=%b, want 9999 ovf=0", r, o); else pass_cnt++;
    run_conv14(14'd16383, lat, r, o);
    total_cnt++;
    if (r !== 16'h9999 || o !== 1'b1) $display("FAIL ovf_16383: got %h ovf=%b, want 9999 ovf=1", r, o); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
